alu_ctrl_mdu: RTL
=================

Name: alu_ctrl_mdu

Overview:
- Execute-stage ALU control decoder, extended to I-format ALU ops and the RV32M multiply/divide extension.
- M-extension ops run on an integrated iterative multiply/divide unit (MDU) parametrised in XLEN.
- The MDU stalls the pipeline while busy and returns one result per accepted op.
- Sits in EX beside the ALU; md_sel steers the writeback mux.

Parameters:
- XLEN, 32, datapath width; a power of two, at least 8.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op_in  in  2  00 add (load/store), 01 sub (branch), 10 R-format, 11 I-format ALU.
- funct3  in  3  instruction bits 14:12.
- funct7_5  in  1  instruction bit 30.
- funct7_0  in  1  instruction bit 25 (M-extension select).
- valid_in  in  1  valid instruction in EX this cycle.
- kill  in  1  flush of EX, synchronous.
- rs1  in  XLEN  operand 1.
- rs2  in  XLEN  operand 2.
- alu_op_out  out  4  ALU encoding from defines.v (ALU_ADD, ALU_SUB, ...).
- md_sel  out  1  EX instruction is an M-op; writeback takes md_result.
- md_busy  out  1  stall request to the pipeline.
- md_done  out  1  one-cycle pulse; md_result valid.
- md_result  out  XLEN  MDU result, held until the next md_done.

Behaviour:
- Decode is combinational:
  - op_in 00 -> ALU_ADD; op_in 01 -> ALU_SUB.
  - op_in 10 with funct7_0=0:
    - 000 -> SUB if funct7_5, else ADD.
    - 101 -> SRA if funct7_5, else SRL.
    - 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND.
  - op_in 11: as op_in 10, except 000 is always ADD.
  - op_in 10 with funct7_0=1: alu_op_out = ALU_PASS, md_sel=1.
  - md_sel=0 in all other cases.
- start = valid_in & md_sel & state==IDLE & ~kill.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE: on start, latch rs1, rs2, funct3 and the operand signs.
    - funct3[2]=0 -> MUL.
    - funct3[2]=1 with a special case -> DONE.
    - otherwise -> DIV.
  - MUL / DIV: run XLEN iterations with a counter (0..XLEN-1), then -> DONE.
  - DONE: md_done=1 and md_result registered; -> IDLE. start is ignored in DONE.
- md_busy = start | state in {MUL, DIV}. It is low in DONE, so the pipeline advances after DONE.
- Latency with the accept cycle as cycle 0:
  - md_busy is high for cycles 0..XLEN; md_done pulses at cycle XLEN+1.
  - Special cases: md_busy high at cycle 0 only; md_done at cycle 1.
- Multiply:
  - Shift-add over operand magnitudes into a 2*XLEN product; negate if the signs differ.
  - MUL (000) low half; MULH (001) s*s high; MULHSU (010) s*u high; MULHU (011) u*u high.
- Divide:
  - Restoring division over magnitudes.
  - Quotient sign = sign(rs1) xor sign(rs2); remainder sign = sign(rs1).
  - DIV 100, DIVU 101, REM 110, REMU 111.
- Special cases (no iteration):
  - rs2==0: quotient all ones, remainder = rs1.
  - Signed rs1 = most negative and rs2 = -1: quotient = rs1, remainder = 0.
- kill: highest priority after reset.
  - Any state -> IDLE next edge; md_busy forced 0 while kill=1.
  - No md_done is issued; md_result is unchanged.
- Reset (asynchronous, any time, including mid-operation):
  - state IDLE; counter, operand and product registers cleared.
  - md_result=0, md_done=0.
  - md_busy=0 while rst_n=0.
- Simultaneous kill and start: kill wins; the op is not accepted.

Optional Feature:
- Macro: MDU_DIVREM_FUSE_EN.
- Defined:
  - Cache the last completed divide's rs1, rs2, signedness, quotient and remainder, plus a valid bit.
  - A divide-class op whose operands and signedness match a valid entry goes IDLE -> DONE: busy at cycle 0, done at cycle 1.
  - The result is taken from the cache.
  - The valid bit is cleared on reset, on kill, and on any completed multiply.
- Undefined: cache logic absent; every non-special divide takes full latency.

Test Plan:
- Decode:
  - op_in=10, f3=101, f7_5=1, f7_0=0 -> ALU_SRA, md_sel=0, md_busy=0.
  - op_in=11, f3=000, f7_5=1 -> ALU_ADD.
- Multiply, rs1=0xFFFFFFFD, rs2=7:
  - MUL -> 0xFFFFFFEB; busy cycles 0..32; done at cycle 33.
  - MULH -> 0xFFFFFFFF; MULHSU -> 0xFFFFFFFF; MULHU -> 0x00000006.
- Divide:
  - DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF.
  - DIVU 100/7 -> 14; REMU 100/7 -> 2; each done at cycle 33.
- Special cases:
  - DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; done at cycle 1.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
- kill and reset:
  - kill at cycle 10 of a DIV -> md_busy 0 that cycle, no md_done, FSM IDLE.
  - A following MUL 6*7 -> 42 at cycle 33.
  - rst_n low mid-MUL -> all outputs 0 immediately.
- Fusion:
  - DIVU 100/7 then REMU 100/7 -> REMU done at cycle 1 with 2 when MDU_DIVREM_FUSE_EN is defined; at cycle 33 when undefined.

Source files
------------

// File: rtl/alu_ctrl_mdu.sv
// alu_ctrl_mdu: EX-stage ALU control decode plus an iterative RV32M multiply/divide unit.
// Latency: decode is combinational; MDU result XLEN+1 cycles after accept (1 cycle for special/fused ops).
// Backpressure: md_busy stalls the pipeline while an op runs; kill flushes. Option: MDU_DIVREM_FUSE_EN.
module alu_ctrl_mdu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      op_in,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic            funct7_0,
    input  logic            valid_in,
    input  logic            kill,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic [3:0]      alu_op_out,
    output logic            md_sel,
    output logic            md_busy,
    output logic            md_done,
    output logic [XLEN-1:0] md_result
);
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_PASS = 4'd10;
    localparam int         CW       = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    state_t state, state_nxt;

    logic            start, cnt_last, running;
    logic [CW-1:0]   cnt;
    logic [2*XLEN-1:0] p, p_step, mul_full;
    logic [XLEN-1:0] b_mag_r, a_mag, b_mag, spec_res, hit_res;
    logic [XLEN-1:0] mul_res, div_res, q_out, r_out, r_sub;
    logic [XLEN:0]   hi_sum, r_shift;
    logic [1:0]      f3_r;
    logic            a_neg_r, b_neg_r, a_sgn, b_sgn, a_neg, b_neg;
    logic            div_zero, div_ovf, special, hit;

    always_comb begin
        alu_op_out = ALU_ADD;
        md_sel     = 1'b0;
        case (op_in)
            2'b00: alu_op_out = ALU_ADD;
            2'b01: alu_op_out = ALU_SUB;
            2'b10, 2'b11: begin
                if (op_in == 2'b10 && funct7_0) begin
                    alu_op_out = ALU_PASS;
                    md_sel     = 1'b1;
                end else begin
                    case (funct3)
                        3'b000: alu_op_out = (op_in == 2'b10 && funct7_5) ? ALU_SUB : ALU_ADD;
                        3'b001: alu_op_out = ALU_SLL;
                        3'b010: alu_op_out = ALU_SLT;
                        3'b011: alu_op_out = ALU_SLTU;
                        3'b100: alu_op_out = ALU_XOR;
                        3'b101: alu_op_out = funct7_5 ? ALU_SRA : ALU_SRL;
                        3'b110: alu_op_out = ALU_OR;
                        3'b111: alu_op_out = ALU_AND;
                    endcase
                end
            end
        endcase
    end

    // Operand signedness: MUL/MULH s*s, MULHSU s*u, MULHU u*u; DIV/REM signed when funct3[0]=0.
    assign a_sgn    = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
    assign b_sgn    = funct3[2] ? ~funct3[0] : ~funct3[1];
    assign a_neg    = a_sgn & rs1[XLEN-1];
    assign b_neg    = b_sgn & rs2[XLEN-1];
    assign a_mag    = a_neg ? -rs1 : rs1;
    assign b_mag    = b_neg ? -rs2 : rs2;
    assign div_zero = (rs2 == '0);
    assign div_ovf  = ~funct3[0] & (rs1 == MIN_NEG) & (rs2 == '1);
    assign special  = funct3[2] & (div_zero | div_ovf);
    assign spec_res = div_zero ? (funct3[1] ? rs1 : '1) : (funct3[1] ? '0 : rs1);

`ifdef MDU_DIVREM_FUSE_EN
    logic            c_vld, c_sgn;
    logic [XLEN-1:0] c_rs1, c_rs2, c_q, c_r, rs1_r, rs2_r;
    assign hit     = funct3[2] & c_vld & (rs1 == c_rs1) & (rs2 == c_rs2) & (c_sgn == ~funct3[0]);
    assign hit_res = funct3[1] ? c_r : c_q;
`else
    assign hit     = 1'b0;
    assign hit_res = '0;
`endif

    assign start    = valid_in & md_sel & (state == IDLE) & ~kill;
    assign running  = (state == MUL) | (state == DIV);
    assign cnt_last = (cnt == CW'(XLEN-1));
    assign md_busy  = rst_n & ~kill & (start | running);
    assign md_done  = (state == DONE) & ~kill;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) begin
                if (!funct3[2])          state_nxt = MUL;
                else if (special || hit) state_nxt = DONE;
                else                     state_nxt = DIV;
            end
            MUL, DIV: if (cnt_last) state_nxt = DONE;
            DONE:     state_nxt = IDLE;
        endcase
        if (kill) state_nxt = IDLE;
    end

    // One iteration: shift-add multiply, or restoring divide with remainder in the upper half.
    always_comb begin
        hi_sum  = {1'b0, p[2*XLEN-1:XLEN]} + (p[0] ? {1'b0, b_mag_r} : '0);
        r_shift = {p[2*XLEN-1:XLEN], p[XLEN-1]};
        r_sub   = r_shift[XLEN-1:0] - b_mag_r;
        if (state == MUL)
            p_step = {hi_sum, p[XLEN-1:1]};
        else if (r_shift >= {1'b0, b_mag_r})
            p_step = {r_sub, p[XLEN-2:0], 1'b1};
        else
            p_step = {r_shift[XLEN-1:0], p[XLEN-2:0], 1'b0};
    end

    assign mul_full = (a_neg_r ^ b_neg_r) ? -p_step : p_step;
    assign mul_res  = (f3_r == 2'b00) ? mul_full[XLEN-1:0] : mul_full[2*XLEN-1:XLEN];
    assign q_out    = (a_neg_r ^ b_neg_r) ? -p_step[XLEN-1:0] : p_step[XLEN-1:0];
    assign r_out    = a_neg_r ? -p_step[2*XLEN-1:XLEN] : p_step[2*XLEN-1:XLEN];
    assign div_res  = f3_r[1] ? r_out : q_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p         <= '0;
            b_mag_r   <= '0;
            cnt       <= '0;
            f3_r      <= '0;
            a_neg_r   <= 1'b0;
            b_neg_r   <= 1'b0;
            md_result <= '0;
        end else if (!kill) begin
            if (start) begin
                p       <= {{XLEN{1'b0}}, a_mag};
                b_mag_r <= b_mag;
                cnt     <= '0;
                f3_r    <= funct3[1:0];
                a_neg_r <= a_neg;
                b_neg_r <= b_neg;
                if (special)  md_result <= spec_res;
                else if (hit) md_result <= hit_res;
            end else if (running) begin
                p   <= p_step;
                cnt <= cnt + CW'(1);
                if (cnt_last) md_result <= (state == MUL) ? mul_res : div_res;
            end
        end
    end

`ifdef MDU_DIVREM_FUSE_EN
    // Cache of the last iterated divide; any completed multiply or a flush invalidates it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_vld <= 1'b0;
            c_sgn <= 1'b0;
            c_rs1 <= '0;
            c_rs2 <= '0;
            c_q   <= '0;
            c_r   <= '0;
            rs1_r <= '0;
            rs2_r <= '0;
        end else if (kill) begin
            c_vld <= 1'b0;
        end else if (start) begin
            rs1_r <= rs1;
            rs2_r <= rs2;
        end else if (running && cnt_last) begin
            if (state == MUL) begin
                c_vld <= 1'b0;
            end else begin
                c_vld <= 1'b1;
                c_sgn <= ~f3_r[0];
                c_rs1 <= rs1_r;
                c_rs2 <= rs2_r;
                c_q   <= q_out;
                c_r   <= r_out;
            end
        end
    end
`endif
endmodule
